// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP CPU port controller.
// Holds the access-code and FSM enums plus port-select constants.
package vdp_pkg;

    localparam logic [1:0] PORT_SEL_DEF = 2'b10;
    localparam logic       PORT_DATA    = 1'b0;
    localparam logic       PORT_CTRL    = 1'b1;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } code_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2
    } state_t;

endpackage

// File: rtl/vdp_bus_strobe.sv
// Z80 strobe edge detect and VDP port decode.
// Ports: clk_i/rst_ni, iorq_ni/rd_ni/wr_ni/addr_i from the bus;
// one-cycle rd/wr pulses per port and read-active levels for bus drive.
module vdp_bus_strobe
    import vdp_pkg::*;
#(
    parameter logic [1:0] PORT_SEL = PORT_SEL_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       iorq_ni,
    input  logic       rd_ni,
    input  logic       wr_ni,
    input  logic [7:0] addr_i,
    output logic       rd_data_o,
    output logic       wr_data_o,
    output logic       rd_ctrl_o,
    output logic       wr_ctrl_o,
    output logic       rd_data_act_o,
    output logic       rd_ctrl_act_o
);

    logic sel;
    logic rd_act;
    logic wr_act;
    logic rd_q;
    logic wr_q;
    logic rd_edge;
    logic wr_edge;
    logic unused_addr;

    assign sel    = (addr_i[7:6] == PORT_SEL);
    assign rd_act = ~iorq_ni & ~rd_ni & sel;
    assign wr_act = ~iorq_ni & ~wr_ni & sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= rd_act;
            wr_q <= wr_act;
        end
    end

    // One action per strobe: only the first active cycle fires.
    assign rd_edge = rd_act & ~rd_q;
    assign wr_edge = wr_act & ~wr_q;

    assign rd_data_o     = rd_edge & (addr_i[0] == PORT_DATA);
    assign rd_ctrl_o     = rd_edge & (addr_i[0] == PORT_CTRL);
    assign wr_data_o     = wr_edge & (addr_i[0] == PORT_DATA);
    assign wr_ctrl_o     = wr_edge & (addr_i[0] == PORT_CTRL);
    assign rd_data_act_o = rd_act & (addr_i[0] == PORT_DATA);
    assign rd_ctrl_act_o = rd_act & (addr_i[0] == PORT_CTRL);

    assign unused_addr = ^addr_i[5:1];

endmodule

// File: rtl/vdp_cpu_port_ctrl.sv
// Z80-side VDP I/O controller: command latch, auto-increment address,
// VRAM/CRAM/register access sequencing.
// Ports: Z80 bus (IORQ_L/RD_L/WR_L, addr/data buses, data_bus_oe),
// status_in/status_rd, VRAM req/gnt channel, cram_* and reg_* write
// pulses, busy. Macro VDP_WAIT_EN selects wait_L stalling; without it
// data accesses while busy are dropped and flagged on overrun.
module vdp_cpu_port_ctrl
    import vdp_pkg::*;
#(
    parameter int         VRAM_AW  = 14,
    parameter int         CRAM_AW  = 5,
    parameter int         REG_AW   = 4,
    parameter logic [1:0] PORT_SEL = 2'b10
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               IORQ_L,
    input  logic               RD_L,
    input  logic               WR_L,
    input  logic [7:0]         addr_bus_in,
    input  logic [7:0]         data_bus_in,
    output logic [7:0]         data_bus_out,
    output logic               data_bus_oe,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic               vram_req,
    input  logic               vram_gnt,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic               cram_we,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [7:0]         cram_wdata,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_addr,
    output logic [7:0]         reg_wdata,
    output logic               busy,
`ifdef VDP_WAIT_EN
    output logic               wait_L
`else
    output logic               overrun
`endif
);

    localparam logic [VRAM_AW-1:0] ONE = VRAM_AW'(1);

    logic rd_data, wr_data, rd_ctrl, wr_ctrl;
    logic rd_data_act, rd_ctrl_act;

    vdp_bus_strobe #(
        .PORT_SEL(PORT_SEL)
    ) u_strobe (
        .clk_i        (clk),
        .rst_ni       (rst_L),
        .iorq_ni      (IORQ_L),
        .rd_ni        (RD_L),
        .wr_ni        (WR_L),
        .addr_i       (addr_bus_in),
        .rd_data_o    (rd_data),
        .wr_data_o    (wr_data),
        .rd_ctrl_o    (rd_ctrl),
        .wr_ctrl_o    (wr_ctrl),
        .rd_data_act_o(rd_data_act),
        .rd_ctrl_act_o(rd_ctrl_act)
    );

    state_t             state_q;
    code_t              code_q;
    logic [VRAM_AW-1:0] addr_q;
    logic               flag_q;
    logic [7:0]         rbuf_q;
    logic [7:0]         dout_q;
    logic               vram_req_q, vram_we_q;
    logic [VRAM_AW-1:0] vram_addr_q;
    logic [7:0]         vram_wdata_q;
    logic               cram_we_q;
    logic [CRAM_AW-1:0] cram_addr_q;
    logic [7:0]         cram_wdata_q;
    logic               reg_we_q;
    logic [REG_AW-1:0]  reg_addr_q;
    logic [7:0]         reg_wdata_q;
    logic               status_rd_q;

    logic               idle;
    logic               do_rd, do_wr;
    logic [7:0]         do_data;
    logic               pf_ctrl;
    logic               v_start;
    logic [VRAM_AW-1:0] v_addr;
    logic [VRAM_AW-1:0] ctrl_addr;
    code_t              new_code;

    assign idle      = (state_q == IDLE);
    assign new_code  = code_t'(data_bus_in[7:6]);
    assign ctrl_addr = {data_bus_in[VRAM_AW-9:0], addr_q[7:0]};

`ifdef VDP_WAIT_EN
    logic       pend_q, pend_wr_q;
    logic [7:0] pend_data_q;
    logic       go_pend, go_new, hold;

    // A data strobe that cannot run now is parked and replayed on IDLE.
    assign go_pend = idle & pend_q;
    assign go_new  = idle & ~pend_q & (rd_data | wr_data);
    assign hold    = (rd_data | wr_data) & ~go_new;
    assign do_rd   = go_pend ? ~pend_wr_q : (go_new & rd_data);
    assign do_wr   = go_pend ? pend_wr_q : (go_new & wr_data);
    assign do_data = go_pend ? pend_data_q : data_bus_in;
    assign wait_L  = ~(pend_q | hold);
`else
    logic overrun_q;
    logic drop;

    assign do_rd   = idle & rd_data;
    assign do_wr   = idle & wr_data;
    assign do_data = data_bus_in;
    assign drop    = ~idle & (rd_data | wr_data);
    assign overrun = overrun_q;
`endif

    always_comb begin
        pf_ctrl = wr_ctrl & flag_q & (new_code == VRAM_RD)
                & idle & ~(do_rd | do_wr);
        v_start = do_rd | (do_wr & (code_q != CRAM_WR)) | pf_ctrl;
        v_addr  = pf_ctrl ? ctrl_addr : addr_q;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q      <= IDLE;
            code_q       <= VRAM_RD;
            addr_q       <= '0;
            flag_q       <= 1'b0;
            rbuf_q       <= '0;
            dout_q       <= '0;
            vram_req_q   <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            cram_we_q    <= 1'b0;
            cram_addr_q  <= '0;
            cram_wdata_q <= '0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            status_rd_q  <= 1'b0;
`ifdef VDP_WAIT_EN
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_data_q  <= '0;
`else
            overrun_q    <= 1'b0;
`endif
        end else begin
            reg_we_q    <= 1'b0;
            cram_we_q   <= 1'b0;
            status_rd_q <= 1'b0;

            if (wr_ctrl) begin
                if (!flag_q) begin
                    addr_q[7:0] <= data_bus_in;
                    flag_q      <= 1'b1;
                end else begin
                    flag_q <= 1'b0;
                    code_q <= new_code;
                    addr_q <= pf_ctrl ? ctrl_addr + ONE : ctrl_addr;
                    if (new_code == REG_WR) begin
                        reg_we_q    <= 1'b1;
                        reg_addr_q  <= data_bus_in[REG_AW-1:0];
                        reg_wdata_q <= addr_q[7:0];
                    end
                end
            end

            if (rd_ctrl) begin
                flag_q      <= 1'b0;
                status_rd_q <= 1'b1;
`ifndef VDP_WAIT_EN
                overrun_q   <= 1'b0;
`endif
            end

            if (rd_data | wr_data) flag_q <= 1'b0;
            // Freeze the returned byte for the rest of the strobe.
            if (rd_data | do_rd) dout_q <= rbuf_q;
            if (do_rd | do_wr) addr_q <= addr_q + ONE;

            if (do_wr) begin
                rbuf_q <= do_data;
                if (code_q == CRAM_WR) begin
                    cram_we_q    <= 1'b1;
                    cram_addr_q  <= addr_q[CRAM_AW-1:0];
                    cram_wdata_q <= do_data;
                end
            end

`ifdef VDP_WAIT_EN
            if (hold) begin
                pend_q      <= 1'b1;
                pend_wr_q   <= wr_data;
                pend_data_q <= data_bus_in;
            end else if (go_pend) begin
                pend_q <= 1'b0;
            end
`else
            if (drop) overrun_q <= 1'b1;
`endif

            unique case (state_q)
                IDLE: begin
                    if (v_start) begin
                        state_q      <= REQ;
                        vram_req_q   <= 1'b1;
                        vram_we_q    <= do_wr;
                        vram_addr_q  <= v_addr;
                        vram_wdata_q <= do_data;
                    end
                end
                REQ: begin
                    if (vram_gnt) begin
                        vram_req_q <= 1'b0;
                        vram_we_q  <= 1'b0;
                        state_q    <= vram_we_q ? IDLE : CAP;
                    end
                end
                CAP: begin
                    rbuf_q  <= vram_rdata;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_bus_out = '0;
        if (rd_ctrl_act) data_bus_out = status_in;
        else if (rd_data_act) data_bus_out = rd_data ? rbuf_q : dout_q;
    end

    assign data_bus_oe = rd_ctrl_act | rd_data_act;
    assign status_rd   = status_rd_q;
    assign vram_req    = vram_req_q;
    assign vram_we     = vram_we_q;
    assign vram_addr   = vram_addr_q;
    assign vram_wdata  = vram_wdata_q;
    assign cram_we     = cram_we_q;
    assign cram_addr   = cram_addr_q;
    assign cram_wdata  = cram_wdata_q;
    assign reg_we      = reg_we_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign busy        = ~idle;

endmodule

// File: tb/tb_vdp_cpu_port_ctrl.sv
// Directed bench for vdp_cpu_port_ctrl.
// Models VRAM/CRAM behind the DUT and drives Z80 I/O cycles.
module tb_vdp_cpu_port_ctrl;
    import vdp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        IORQ_L = 1'b1, RD_L = 1'b1, WR_L = 1'b1;
    logic [7:0]  addr_bus_in = '0, data_bus_in = '0;
    logic [7:0]  data_bus_out;
    logic        data_bus_oe;
    logic [7:0]  status_in = '0;
    logic        status_rd;
    logic        vram_req, vram_gnt = 1'b1;
    logic [13:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata, vram_rdata = '0;
    logic        cram_we;
    logic [4:0]  cram_addr;
    logic [7:0]  cram_wdata;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        busy;
`ifdef VDP_WAIT_EN
    logic        wait_L;
`else
    logic        overrun;
`endif

    vdp_cpu_port_ctrl dut (
        .clk(clk), .rst_L(rst_L),
        .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .addr_bus_in(addr_bus_in), .data_bus_in(data_bus_in),
        .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
        .status_in(status_in), .status_rd(status_rd),
        .vram_req(vram_req), .vram_gnt(vram_gnt),
        .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .cram_we(cram_we), .cram_addr(cram_addr),
        .cram_wdata(cram_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .busy(busy),
`ifdef VDP_WAIT_EN
        .wait_L(wait_L)
`else
        .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  vmem [0:16383];
    logic [7:0]  cmem [0:31];
    int          n_vacc = 0, n_reg = 0, n_cram = 0, n_strd = 0;
    logic [13:0] last_vaddr = '0;
    logic [3:0]  reg_a = '0;
    logic [7:0]  reg_d = '0;
    logic        wait_seen = 1'b0;

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (vram_req && vram_gnt) begin
            n_vacc++;
            last_vaddr <= vram_addr;
            if (vram_we) vmem[vram_addr] <= vram_wdata;
            else vram_rdata <= vmem[vram_addr];
        end
        if (reg_we) begin
            n_reg++;
            reg_a <= reg_addr;
            reg_d <= reg_wdata;
        end
        if (cram_we) begin
            n_cram++;
            cmem[cram_addr] <= cram_wdata;
        end
        if (status_rd) n_strd++;
    end

    task automatic stall_wait();
`ifdef VDP_WAIT_EN
        if (!wait_L) wait_seen = 1'b1;
        for (int i = 0; i < 100 && !wait_L; i++) @(negedge clk);
        if (!wait_L) chk("wait_timeout", wait_L, 1);
`endif
    endtask

    task automatic io_wr(input logic port, input logic [7:0] d);
        @(negedge clk);
        addr_bus_in = {2'b10, 5'b0, port};
        data_bus_in = d;
        IORQ_L = 1'b0;
        WR_L = 1'b0;
        repeat (3) @(negedge clk);
        stall_wait();
        IORQ_L = 1'b1;
        WR_L = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic io_rd(input logic port,
                         output logic [7:0] d,
                         output logic oe);
        @(negedge clk);
        addr_bus_in = {2'b10, 5'b0, port};
        IORQ_L = 1'b0;
        RD_L = 1'b0;
        repeat (3) @(negedge clk);
        stall_wait();
        d = data_bus_out;
        oe = data_bus_oe;
        IORQ_L = 1'b1;
        RD_L = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       oe;
        int         v0;

        for (int i = 0; i < 16384; i++) vmem[i] = 8'hEE;
        for (int i = 0; i < 32; i++) cmem[i] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req", vram_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oe", data_bus_oe, 0);
        chk("rst_we", {reg_we, cram_we, vram_we, status_rd}, 0);
        chk("rst_dout", data_bus_out, 0);
`ifdef VDP_WAIT_EN
        chk("rst_wait", wait_L, 1);
`else
        chk("rst_ovr", overrun, 0);
`endif
        rst_L = 1'b1;
        repeat (2) @(negedge clk);

        // VRAM write stream at 0000
        io_wr(PORT_CTRL, 8'h00);
        io_wr(PORT_CTRL, 8'h40);
        io_wr(PORT_DATA, 8'hAB);
        io_wr(PORT_DATA, 8'hCD);
        wait_idle();
        chk("vram0", vmem[0], 8'hAB);
        chk("vram1", vmem[1], 8'hCD);
        chk("vacc_wr", n_vacc, 2);
        io_rd(PORT_DATA, rd, oe);
        wait_idle();
        chk("rbuf_from_wr", rd, 8'hCD);
        chk("rd_oe", oe, 1);
        chk("addr_0002", last_vaddr, 14'h0002);

        // register write
        v0 = n_vacc;
        io_wr(PORT_CTRL, 8'h05);
        io_wr(PORT_CTRL, 8'h81);
        chk("reg_cnt", n_reg, 1);
        chk("reg_addr", reg_a, 4'h1);
        chk("reg_data", reg_d, 8'h05);
        chk("reg_novram", n_vacc, v0);

        // CRAM write with 31 -> 0 wrap
        io_wr(PORT_CTRL, 8'h1F);
        io_wr(PORT_CTRL, 8'hC0);
        io_wr(PORT_DATA, 8'h3C);
        io_wr(PORT_DATA, 8'h0F);
        chk("cram31", cmem[31], 8'h3C);
        chk("cram0", cmem[0], 8'h0F);
        chk("cram_cnt", n_cram, 2);
        chk("cram_novram", n_vacc, v0);

        // read prefetch across 3FFF -> 0000
        vmem[14'h3FFF] = 8'h77;
        vmem[0] = 8'h88;
        io_wr(PORT_CTRL, 8'hFF);
        io_wr(PORT_CTRL, 8'h3F);
        wait_idle();
        io_rd(PORT_DATA, rd, oe);
        wait_idle();
        chk("rd_3fff", rd, 8'h77);
        io_rd(PORT_DATA, rd, oe);
        wait_idle();
        chk("rd_0000", rd, 8'h88);
        chk("rd_addr_0001", last_vaddr, 14'h0001);

        // status read clears the byte latch
        status_in = 8'h5A;
        io_wr(PORT_CTRL, 8'h12);
        io_rd(PORT_CTRL, rd, oe);
        chk("status", rd, 8'h5A);
        chk("status_rd", n_strd, 1);
        io_wr(PORT_CTRL, 8'h34);
        io_wr(PORT_CTRL, 8'h40);
        io_wr(PORT_DATA, 8'h99);
        wait_idle();
        chk("flag_clr", vmem[14'h0034], 8'h99);

        // stalled grant with back-to-back writes
        io_wr(PORT_CTRL, 8'h00);
        io_wr(PORT_CTRL, 8'h60);
        vram_gnt = 1'b0;
        fork
            begin
                repeat (14) @(negedge clk);
                vram_gnt = 1'b1;
            end
            begin
                io_wr(PORT_DATA, 8'h11);
                chk("busy_stall", busy, 1);
`ifdef VDP_WAIT_EN
                io_wr(PORT_DATA, 8'h22);
`else
                io_wr(PORT_DATA, 8'h22);
                chk("overrun_set", overrun, 1);
                chk("busy_still", busy, 1);
`endif
            end
        join
        wait_idle();
        chk("stall_w0", vmem[14'h2000], 8'h11);
`ifdef VDP_WAIT_EN
        chk("wait_seen", wait_seen, 1);
        chk("stall_w1", vmem[14'h2001], 8'h22);
`else
        chk("drop_w1", vmem[14'h2001], 8'hEE);
        io_wr(PORT_DATA, 8'h33);
        wait_idle();
        chk("noinc_w1", vmem[14'h2001], 8'h33);
        io_rd(PORT_CTRL, rd, oe);
        chk("overrun_clr", overrun, 0);
`endif

        // reset in the middle of a pending write
        vram_gnt = 1'b0;
        io_wr(PORT_DATA, 8'h55);
        chk("mid_req", vram_req, 1);
        v0 = n_vacc;
        #2 rst_L = 1'b0;
        #1;
        chk("mid_req_drop", vram_req, 0);
        chk("mid_busy", busy, 0);
        vram_gnt = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_nowrite", vmem[14'h2002], 8'hEE);
        chk("mid_noacc", n_vacc, v0);
        rst_L = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
